// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prbs_pkg
// Purpose  : Shared definitions for the PRBS15 checker: frame width, the
//            checker FSM state type and encodings, and the PRBS15 successor
//            function used to predict the next frame.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package prbs_pkg;

    localparam int PRBS15_W = 15;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_SEARCH = 2'd0;
    localparam state_t c_ST_VERIFY = 2'd1;
    localparam state_t c_ST_LOCKED = 2'd2;

    // Successor of frame x for the x^15 + x^14 + 1 generator.
    function automatic logic [PRBS15_W-1:0] prbs15_next(input logic [PRBS15_W-1:0] x);
        return {x[13:0], x[14] ^ x[13]};
    endfunction

endpackage : prbs_pkg
`default_nettype wire

// File: rtl/popcount15.sv
`default_nettype none
// ============================================================================
// Module   : popcount15
// Purpose  : Combinational population count of a 15-bit word.
// Ports    : i_data  [14:0] word to count
//            o_count [3:0]  number of set bits, 0..15
// Revision : 1.0 - initial release
// ============================================================================
module popcount15
    import prbs_pkg::*;
(
    input  logic [PRBS15_W-1:0] i_data,
    output logic [3:0]          o_count
);

    logic [3:0] w_sum;

    always_comb begin
        w_sum = 4'd0;
        for (int i = 0; i < PRBS15_W; i++) begin
            w_sum = w_sum + {3'b000, i_data[i]};
        end
    end

    assign o_count = w_sum;

endmodule : popcount15
`default_nettype wire

// File: rtl/prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : prbs15_checker
// Purpose  : Frame-wise PRBS15 checker. Seeds a prediction from the incoming
//            stream, verifies it over LOCK_THRESH consecutive frames, then
//            free-runs the prediction while LOCKED and counts bit errors and
//            checked frames until UNLOCK_THRESH consecutive bad frames.
// Ports    : clk_i        clock, rising edge
//            rst_i        synchronous active-high reset
//            data_i[14:0] received frame
//            valid_i      data_i carries a new frame this cycle
//            clear_i      synchronous clear of err_cnt_o / frame_cnt_o
//            locked_o     checker is in LOCKED
//            err_o        previous accepted frame mismatched while LOCKED
//            err_bits_o   number of bad bits in that frame
//            err_cnt_o    saturating bit-error count while LOCKED
//            frame_cnt_o  saturating checked-frame count while LOCKED
// Revision : 1.0 - initial release
// ============================================================================
module prbs15_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 4,
    parameter int CNT_W         = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [PRBS15_W-1:0] data_i,
    input  logic                valid_i,
    input  logic                clear_i,
    output logic                locked_o,
    output logic                err_o,
    output logic [3:0]          err_bits_o,
    output logic [CNT_W-1:0]    err_cnt_o,
    output logic [CNT_W-1:0]    frame_cnt_o
);

    localparam int c_GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int c_BAD_W  = $clog2(UNLOCK_THRESH + 1);

    localparam logic [c_GOOD_W-1:0] c_LOCK_CNT   = c_GOOD_W'(LOCK_THRESH);
    localparam logic [c_BAD_W-1:0]  c_UNLOCK_CNT = c_BAD_W'(UNLOCK_THRESH);

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t                r_state;
    logic [PRBS15_W-1:0]   r_expected;
    logic [c_GOOD_W-1:0]   r_good_cnt;
    logic [c_BAD_W-1:0]    r_bad_cnt;
    logic                  r_err;
    logic [3:0]            r_err_bits;
    logic [CNT_W-1:0]      r_err_cnt;
    logic [CNT_W-1:0]      r_frame_cnt;

    state_t                w_state_nxt;
    logic [PRBS15_W-1:0]   w_expected_nxt;
    logic [c_GOOD_W-1:0]   w_good_nxt;
    logic [c_BAD_W-1:0]    w_bad_nxt;
    logic                  w_err_nxt;
    logic [3:0]            w_err_bits_nxt;
    logic [CNT_W-1:0]      w_err_cnt_nxt;
    logic [CNT_W-1:0]      w_frame_cnt_nxt;

    logic                  w_match;
    logic                  w_zero;
    logic                  w_check;
    logic [3:0]            w_pop;
    logic [c_GOOD_W-1:0]   w_good_inc;
    logic [c_BAD_W-1:0]    w_bad_inc;
    logic [CNT_W:0]        w_frame_sum;
    logic [CNT_W:0]        w_err_sum;

    assign w_match    = (data_i == r_expected);
    assign w_zero     = (data_i == '0);
    assign w_check    = valid_i && (r_state == c_ST_LOCKED);
    assign w_good_inc = r_good_cnt + 1'b1;
    assign w_bad_inc  = r_bad_cnt + 1'b1;

    popcount15 u_popcount (
        .i_data  (data_i ^ r_expected),
        .o_count (w_pop)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= c_ST_SEARCH;
            r_expected  <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err       <= 1'b0;
            r_err_bits  <= 4'd0;
            r_err_cnt   <= '0;
            r_frame_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_expected  <= w_expected_nxt;
            r_good_cnt  <= w_good_nxt;
            r_bad_cnt   <= w_bad_nxt;
            r_err       <= w_err_nxt;
            r_err_bits  <= w_err_bits_nxt;
            r_err_cnt   <= w_err_cnt_nxt;
            r_frame_cnt <= w_frame_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_expected_nxt = r_expected;
        w_good_nxt     = r_good_cnt;
        w_bad_nxt      = r_bad_cnt;

        if (valid_i) begin
            case (r_state)
                c_ST_SEARCH: begin
                    // The all-zero word is the LFSR lock-up state; never seed on it.
                    if (!w_zero) begin
                        w_expected_nxt = prbs15_next(data_i);
                        w_good_nxt     = '0;
                        w_state_nxt    = c_ST_VERIFY;
                    end
                end
                c_ST_VERIFY: begin
                    // Both branches reseed from data_i: on a match it equals the
                    // prediction, on a mismatch it restarts the verification run.
                    w_expected_nxt = prbs15_next(data_i);
                    if (w_match) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == c_LOCK_CNT) begin
                            w_bad_nxt   = '0;
                            w_state_nxt = c_ST_LOCKED;
                        end
                    end else begin
                        w_good_nxt = '0;
                        if (w_zero) begin
                            w_state_nxt = c_ST_SEARCH;
                        end
                    end
                end
                c_ST_LOCKED: begin
                    // Free-run the prediction so corrupted input cannot derail it.
                    w_expected_nxt = prbs15_next(r_expected);
                    if (w_match) begin
                        w_bad_nxt = '0;
                    end else begin
                        w_bad_nxt = w_bad_inc;
                        if (w_bad_inc == c_UNLOCK_CNT) begin
                            w_state_nxt = c_ST_SEARCH;
                        end
                    end
                end
                default: begin
                    w_state_nxt = c_ST_SEARCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_frame_sum     = {1'b0, r_frame_cnt} + {{CNT_W{1'b0}}, 1'b1};
        w_err_sum       = {1'b0, r_err_cnt} + {{(CNT_W-3){1'b0}}, w_pop};
        w_err_nxt       = w_check && !w_match;
        w_err_bits_nxt  = w_check ? w_pop : 4'd0;
        w_err_cnt_nxt   = r_err_cnt;
        w_frame_cnt_nxt = r_frame_cnt;

        if (clear_i) begin
            w_err_cnt_nxt   = '0;
            w_frame_cnt_nxt = '0;
        end else if (w_check) begin
            // Carry out of the widened sum means the counter would wrap; pin it.
            w_frame_cnt_nxt = w_frame_sum[CNT_W] ? {CNT_W{1'b1}} : w_frame_sum[CNT_W-1:0];
            w_err_cnt_nxt   = w_err_sum[CNT_W]   ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
        end
    end

    assign locked_o    = (r_state == c_ST_LOCKED);
    assign err_o       = r_err;
    assign err_bits_o  = r_err_bits;
    assign err_cnt_o   = r_err_cnt;
    assign frame_cnt_o = r_frame_cnt;

endmodule : prbs15_checker
`default_nettype wire

// File: tb/tb_prbs15_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_prbs15_checker
// Purpose  : Directed scoreboard bench for prbs15_checker (counters at 6 bits
//            so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prbs15_checker;

    localparam int c_CNT_W = 6;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                valid = 1'b0;
    logic                clr = 1'b0;
    logic [14:0]         data = 15'h0;
    logic                locked;
    logic                err;
    logic [3:0]          err_bits;
    logic [c_CNT_W-1:0]  err_cnt;
    logic [c_CNT_W-1:0]  frame_cnt;

    always #5 clk = ~clk;

    prbs15_checker #(
        .LOCK_THRESH   (4),
        .UNLOCK_THRESH (4),
        .CNT_W         (c_CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .data_i      (data),
        .valid_i     (valid),
        .clear_i     (clr),
        .locked_o    (locked),
        .err_o       (err),
        .err_bits_o  (err_bits),
        .err_cnt_o   (err_cnt),
        .frame_cnt_o (frame_cnt)
    );

    typedef struct {
        int                 due;
        logic               lk;
        logic               er;
        logic [3:0]         bits;
        logic [c_CNT_W-1:0] ec;
        logic [c_CNT_W-1:0] fc;
        string              nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each expectation is due after the edge that captured its stimulus.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            m_e = q.pop_front();
            total++;
            if (m_e.due != cyc || locked !== m_e.lk || err !== m_e.er ||
                err_bits !== m_e.bits || err_cnt !== m_e.ec || frame_cnt !== m_e.fc) begin
                bad++;
                $display("FAIL %s: got lk=%0b err=%0b bits=%0d ec=%0d fc=%0d, want lk=%0b err=%0b bits=%0d ec=%0d fc=%0d",
                         m_e.nm, locked, err, err_bits, err_cnt, frame_cnt,
                         m_e.lk, m_e.er, m_e.bits, m_e.ec, m_e.fc);
            end
        end
    end

    function automatic logic [14:0] nxt(input logic [14:0] x);
        logic [14:0] y;
        y = x << 1;
        y[0] = x[14] ^ x[13];
        return y;
    endfunction

    task automatic send(input logic [14:0] d, input logic v, input logic c, input logic r,
                        input logic lk, input logic e, input int b, input int ec, input int fc,
                        input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        data  = d;
        valid = v;
        clr   = c;
        rst   = r;
        x.due  = cyc + 1;
        x.lk   = lk;
        x.er   = e;
        x.bits = 4'(b);
        x.ec   = c_CNT_W'(ec);
        x.fc   = c_CNT_W'(fc);
        x.nm   = nm;
        q.push_back(x);
    endtask

    initial begin
        logic [14:0] cur;
        int          f;
        int          wait_cyc;

        // Reset state
        send(15'h1234, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, "reset0");
        send(15'h0001, 1'b1, 1'b0, 1'b1, 0, 0, 0, 0, 0, "reset1");

        // Acquire lock from seed 1: locked after the 5th frame, counters untouched
        cur = 15'h0001;
        send(cur, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, "seed");
        for (int i = 1; i <= 4; i++) begin
            cur = nxt(cur);
            send(cur, 1'b1, 1'b0, 1'b0, (i == 4), 0, 0, 0, 0, "acquire");
        end
        for (int i = 1; i <= 3; i++) begin
            cur = nxt(cur);
            send(cur, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, i, "locked_good");
        end

        // Single frame with 3 corrupted bits
        cur = nxt(cur);
        send(cur ^ 15'h0007, 1'b1, 1'b0, 1'b0, 1, 1, 3, 3, 4, "err3");
        cur = nxt(cur);
        send(cur, 1'b1, 1'b0, 1'b0, 1, 0, 0, 3, 5, "after_err3");

        // valid toggling: idle cycles change nothing
        for (int i = 1; i <= 4; i++) begin
            send(15'h7FFF, 1'b0, 1'b0, 1'b0, 1, 0, 0, 3, 4 + i, "idle");
            cur = nxt(cur);
            send(cur, 1'b1, 1'b0, 1'b0, 1, 0, 0, 3, 5 + i, "toggle_valid");
        end

        // clear coincident with an errored frame wins over the increment
        cur = nxt(cur);
        send(cur ^ 15'h0001, 1'b1, 1'b1, 1'b0, 1, 1, 1, 0, 0, "clear_err");
        cur = nxt(cur);
        send(cur, 1'b1, 1'b0, 1'b0, 1, 0, 0, 0, 1, "after_clear");

        // Four consecutive bad frames drop lock; the exit frame is counted
        for (int i = 1; i <= 4; i++) begin
            cur = nxt(cur);
            send(cur ^ 15'h4000, 1'b1, 1'b0, 1'b0, (i < 4), 1, 1, i, 1 + i, "unlock");
        end

        // Counters persist in SEARCH; zero frames do not seed
        send(15'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4, 5, "search_zero0");
        send(15'h5555, 1'b0, 1'b0, 1'b0, 0, 0, 0, 4, 5, "search_idle");
        send(15'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4, 5, "search_zero1");

        // Relock with a reseed in VERIFY: 4 matches are needed after the reseed
        send(15'h1234, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4, 5, "reseed_seed");
        cur = 15'h0F0F;
        send(cur, 1'b1, 1'b0, 1'b0, 0, 0, 0, 4, 5, "reseed_miss");
        for (int i = 1; i <= 4; i++) begin
            cur = nxt(cur);
            send(cur, 1'b1, 1'b0, 1'b0, (i == 4), 0, 0, 4, 5, "relock");
        end

        // Error counter saturation (6-bit max 63)
        cur = nxt(cur); send(cur ^ 15'h7FFF, 1'b1, 1'b0, 1'b0, 1, 1, 15, 19, 6, "sat_e1");
        cur = nxt(cur); send(cur ^ 15'h7FFF, 1'b1, 1'b0, 1'b0, 1, 1, 15, 34, 7, "sat_e2");
        cur = nxt(cur); send(cur ^ 15'h7FFF, 1'b1, 1'b0, 1'b0, 1, 1, 15, 49, 8, "sat_e3");
        cur = nxt(cur); send(cur,            1'b1, 1'b0, 1'b0, 1, 0, 0,  49, 9, "sat_good1");
        cur = nxt(cur); send(cur ^ 15'h7FFF, 1'b1, 1'b0, 1'b0, 1, 1, 15, 63, 10, "sat_e4");
        cur = nxt(cur); send(cur ^ 15'h7FFF, 1'b1, 1'b0, 1'b0, 1, 1, 15, 63, 11, "sat_e5");
        cur = nxt(cur); send(cur,            1'b1, 1'b0, 1'b0, 1, 0, 0,  63, 12, "sat_good2");

        // Frame counter saturation
        for (int k = 1; k <= 55; k++) begin
            f = (12 + k > 63) ? 63 : 12 + k;
            cur = nxt(cur);
            send(cur, 1'b1, 1'b0, 1'b0, 1, 0, 0, 63, f, "sat_frame");
        end

        // Reset mid-LOCKED beats valid and clear
        cur = nxt(cur);
        send(cur ^ 15'h7FFF, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, "reset_locked");

        // All-zero stream never locks
        for (int i = 0; i < 6; i++) begin
            send(15'h0000, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0, "zero_stream");
        end

        @(posedge clk);
        #1;
        valid = 1'b0;
        clr   = 1'b0;
        data  = 15'h0;

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        if (q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prbs15_checker
`default_nettype wire

// File: doc/prbs15_checker.md
PRBS15_CHECKER -- requirements
Module: prbs15_checker

Interface
REQ-001 Parameter LOCK_THRESH, default 4: consecutive matching frames required to declare lock.
REQ-002 Parameter UNLOCK_THRESH, default 4: consecutive mismatching frames required to drop lock.
REQ-003 Parameter CNT_W, default 32: width of the error and frame counters.
REQ-004 clk_i  input  1  single clock; all logic rising-edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 data_i  input  15  received PRBS15 frame.
REQ-007 valid_i  input  1  data_i holds a new frame this cycle; low = source frozen, frame ignored.
REQ-008 clear_i  input  1  synchronous clear of err_cnt_o and frame_cnt_o.
REQ-009 locked_o  output  1  checker is in LOCKED.
REQ-010 err_o  output  1  previous accepted frame mismatched while LOCKED.
REQ-011 err_bits_o  output  4  number of mismatching bits in that frame, range 0..15.
REQ-012 err_cnt_o  output  CNT_W  accumulated bit errors while LOCKED.
REQ-013 frame_cnt_o  output  CNT_W  frames checked while LOCKED.

Function
REQ-014 The checker SHALL use next(x) = {x[13:0], x[14]^x[13]} as the successor of every frame x.
REQ-015 The FSM SHALL have the states SEARCH, VERIFY and LOCKED; the cycles where valid_i=0 SHALL change no state, counter or expected register.
REQ-016 In SEARCH, a valid nonzero frame SHALL load expected=next(data_i), clear good_cnt and move to VERIFY; a valid all-zero frame SHALL keep the FSM in SEARCH.
REQ-017 In VERIFY, if data_i==expected, the block SHALL increment good_cnt and set expected=next(data_i); when good_cnt reaches LOCK_THRESH it SHALL move to LOCKED with bad_cnt=0.
REQ-018 In VERIFY, a mismatch SHALL reseed expected=next(data_i) and zero good_cnt, staying in VERIFY; a mismatched all-zero frame SHALL instead return to SEARCH.
REQ-019 In LOCKED, expected SHALL advance as next(expected) independent of data_i, so that a corrupted frame does not corrupt the prediction.
REQ-020 In LOCKED, a mismatch SHALL increment bad_cnt, and a match SHALL zero bad_cnt; when bad_cnt reaches UNLOCK_THRESH the FSM SHALL go to SEARCH.
REQ-021 err_o and err_bits_o SHALL be registered, valid one cycle after the accepted frame, and SHALL be 0 when the frame was not checked in LOCKED.
REQ-022 err_bits_o SHALL equal popcount(data_i ^ expected).
REQ-023 In LOCKED, each valid frame SHALL increment frame_cnt_o by 1 and add err_bits_o to err_cnt_o; both counters SHALL saturate at all-ones and SHALL never wrap.
REQ-024 clear_i SHALL take priority over a simultaneous increment, so that both counters read 0 on the next cycle; clear_i SHALL not affect the FSM.
REQ-025 The frame that causes the transition to LOCKED SHALL not be counted; the frame that causes the exit from LOCKED SHALL be counted.
REQ-026 The counters SHALL keep their values across loss of lock.

Reset
REQ-027 rst_i SHALL force SEARCH and set expected, good_cnt, bad_cnt and all outputs to 0, including when the FSM is mid-VERIFY or LOCKED.
REQ-028 rst_i SHALL take priority over valid_i and clear_i.

Structure
REQ-029 A shared package prbs_pkg SHALL hold PRBS15_W=15, the FSM state typedef and the next() function.
REQ-030 One sub-module, popcount15, SHALL compute the combinational 15-bit popcount.

Verification
REQ-031 Seed 15'h0001 followed by correct successors, valid_i=1 -> locked_o=1 one cycle after the 5th frame; err_cnt_o stays 0.
REQ-032 While locked, inject data_i ^ 15'h0007 on one frame -> err_o=1 and err_bits_o=3 for one cycle, err_cnt_o +3, locked_o stays 1.
REQ-033 While locked, 4 consecutive corrupted frames -> locked_o=0 after the 4th frame, and frame_cnt_o includes all 4 frames.
REQ-034 All-zero input stream -> FSM stays in SEARCH and locked_o never asserts.
REQ-035 Locked stream with valid_i toggled 0/1 every cycle -> no errors, and frame_cnt_o counts only the valid cycles.
REQ-036 clear_i asserted on the same cycle as an errored frame -> counters read 0; rst_i asserted mid-LOCKED -> all outputs 0 on the next cycle.
